// File: rtl/fifo_rd_sched_pkg.sv
// Shared FIFO definitions: default depth, read-scheduler state encoding and
// Gray conversions. The write-side controller imports the Gray helpers too.
package fifo_rd_sched_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } rd_state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not own the last burst wins.
// Latency: combinational. Backpressure: none, pure decode of req0/req1/last.
// No state of its own; the caller keeps 'last'.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win_vld,
    output logic win_id
);

    always_comb begin
        win_vld = req0 | req1;
        win_id  = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Async-FIFO read-domain controller: shares the read port between two consumers with bounded round-robin bursts.
// Latency: gnt/rd_en combinational with req; rvalid/rdst one rclk later. Optional FIFO_RD_LEVEL_EN adds rlevel.
// Backpressure: reads are withheld while rempty=1; a stalled burst keeps its owner and beat count.
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int BURST_LEN  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic                  req0,
    input  logic                  req1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDR_WIDTH:0]   rlevel,
`endif
    output logic                  rempty,
    output logic                  rvalid,
    output logic                  rdst
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN);
    localparam bit BURST_ONE = (BURST_LEN == 1);

    rd_state_e       state_q, state_d;
    logic            owner_q, owner_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            last_q, last_d;
    logic [PW-1:0]   rbin_q, rbin_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            rempty_q, rempty_d;
    logic            rvalid_q, rvalid_d;
    logic            rdst_q, rdst_d;

    logic win_vld, win_id, owner_req, fire, fire_id;

    rr_arb2 u_arb (
        .req0    (req0),
        .req1    (req1),
        .last    (last_q),
        .win_vld (win_vld),
        .win_id  (win_id)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beat_d    = beat_q;
        last_d    = last_q;
        fire      = 1'b0;
        fire_id   = owner_q;
        owner_req = owner_q ? req1 : req0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !rempty_q) begin
                    fire    = 1'b1;
                    fire_id = win_id;
                    if (BURST_ONE) begin
                        last_d = win_id;
                    end else begin
                        state_d = ST_BUSY;
                        owner_d = win_id;
                        beat_d  = BW'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    beat_d  = '0;
                end else if (!rempty_q) begin
                    fire = 1'b1;
                    if (beat_q + BW'(1) == BURST_LAST) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Empty is judged against the pointer after this cycle's read.
        rbin_d   = rbin_q + {{ADDR_WIDTH{1'b0}}, fire};
        rptr_d   = PW'(bin2gray(32'(rbin_d)));
        rempty_d = (rptr_d == rq2_wptr);
        rvalid_d = fire;
        rdst_d   = fire ? fire_id : rdst_q;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            beat_q   <= '0;
            last_q   <= 1'b1;
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rvalid_q <= 1'b0;
            rdst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            rvalid_q <= rvalid_d;
            rdst_q   <= rdst_d;
        end
    end

    always_comb begin
        gnt0   = fire & ~fire_id;
        gnt1   = fire & fire_id;
        rd_en  = fire;
        raddr  = rbin_q[ADDR_WIDTH-1:0];
        rptr   = rptr_q;
        rempty = rempty_q;
        rvalid = rvalid_q;
        rdst   = rdst_q;
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin;
    always_comb begin
        wbin   = PW'(gray2bin(32'(rq2_wptr)));
        rlevel = rempty_q ? '0 : (wbin - rbin_q);
    end
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched (ADDR_WIDTH=3, BURST_LEN=4) with hand-computed expectations.
module tb_fifo_rd_sched;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [3:0] rq2_wptr;
    logic       req0, req1;
    logic       gnt0, gnt1, rd_en, rempty, rvalid, rdst;
    logic [2:0] raddr;
    logic [3:0] rptr;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0] rlevel;
`endif

    int n_vec = 0;
    int n_bad = 0;

    int fire_id[16];
    int fire_addr[16];
    int dst_seen[16];
    int nf, nd;

    fifo_rd_sched #(.ADDR_WIDTH(3), .BURST_LEN(4)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rq2_wptr (rq2_wptr),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rd_en    (rd_en),
        .raddr    (raddr),
        .rptr     (rptr),
`ifdef FIFO_RD_LEVEL_EN
        .rlevel   (rlevel),
`endif
        .rempty   (rempty),
        .rvalid   (rvalid),
        .rdst     (rdst)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [3:0] g(input int n);
        logic [3:0] b;
        b = 4'(n);
        return (b >> 1) ^ b;
    endfunction

    task automatic do_reset();
        rrst = 1'b1; req0 = 1'b0; req1 = 1'b0; rq2_wptr = 4'b0000;
        cyc(); cyc();
        rrst = 1'b0;
    endtask

    initial begin
        // Reset with both requests up and a non-empty write pointer.
        rrst = 1'b1; req0 = 1'b1; req1 = 1'b1; rq2_wptr = 4'b0101;
        cyc(); cyc();
        chk("rst_rptr",   32'(rptr),   32'd0);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_rd_en",  32'(rd_en),  32'd0);
        chk("rst_gnt0",   32'(gnt0),   32'd0);
        chk("rst_gnt1",   32'(gnt1),   32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        rrst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        cyc();
        chk("rst_rel_rempty", 32'(rempty), 32'd0);

        // Empty stall.
        rq2_wptr = 4'b0000;
        cyc();
        chk("stall_rempty", 32'(rempty), 32'd1);
        req0 = 1'b1;
        #1 chk("stall_rd_en0", 32'(rd_en), 32'd0);
        cyc();
        chk("stall_rd_en1", 32'(rd_en), 32'd0);
        chk("stall_rvalid", 32'(rvalid), 32'd0);
        rq2_wptr = 4'b0001;
        cyc();
        chk("stall_rempty_clr", 32'(rempty), 32'd0);
        #1;
        chk("stall_fire_rd_en", 32'(rd_en), 32'd1);
        chk("stall_fire_gnt0",  32'(gnt0),  32'd1);
        chk("stall_fire_raddr", 32'(raddr), 32'd0);
        cyc();
        chk("stall_rvalid1", 32'(rvalid), 32'd1);
        chk("stall_rdst",    32'(rdst),   32'd0);
        chk("stall_rptr",    32'(rptr),   32'd1);
        chk("stall_rempty1", 32'(rempty), 32'd1);
        req0 = 1'b0;
        cyc();

        // Round-robin bursts over 8 words.
        do_reset();
        rq2_wptr = 4'b1100;
        cyc();
        chk("rr_rempty", 32'(rempty), 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        nf = 0; nd = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rd_en && nf < 16) begin
                fire_id[nf]   = int'(gnt1);
                fire_addr[nf] = int'(raddr);
                nf++;
            end
            cyc();
            if (rvalid && nd < 16) begin
                dst_seen[nd] = int'(rdst);
                nd++;
            end
        end
        chk("rr_fire_count",   32'(nf), 32'd8);
        chk("rr_rvalid_count", 32'(nd), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < nf) begin
                chk($sformatf("rr_id%0d", i),   32'(fire_id[i]),   32'(i / 4));
                chk($sformatf("rr_addr%0d", i), 32'(fire_addr[i]), 32'(i));
            end
            if (i < nd) chk($sformatf("rr_rdst%0d", i), 32'(dst_seen[i]), 32'(i / 4));
        end
        chk("rr_rempty_end", 32'(rempty), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        cyc();

        // Early release after two beats of consumer 0.
        do_reset();
        rq2_wptr = g(8);
        cyc();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("er_gnt0_b1", 32'(gnt0), 32'd1);
        chk("er_addr_b1", 32'(raddr), 32'd0);
        cyc();
        #1;
        chk("er_gnt0_b2", 32'(gnt0), 32'd1);
        chk("er_addr_b2", 32'(raddr), 32'd1);
        cyc();
        req0 = 1'b0;
        #1;
        chk("er_rel_gnt1", 32'(gnt1), 32'd0);
        chk("er_rel_rd_en", 32'(rd_en), 32'd0);
        cyc();
        #1;
        chk("er_gnt1_a", 32'(gnt1), 32'd1);
        chk("er_addr_a", 32'(raddr), 32'd2);
        cyc();
        #1;
        chk("er_gnt1_b", 32'(gnt1), 32'd1);
        chk("er_addr_b", 32'(raddr), 32'd3);
        req1 = 1'b0;
        cyc();

        // Wrap: 16 writes streamed through by consumer 0, writer kept two ahead.
        do_reset();
        rq2_wptr = g(2);
        cyc();
        chk("wrap_rempty0", 32'(rempty), 32'd0);
        req0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rq2_wptr = g((i + 2 > 16) ? 16 : i + 2);
            #1;
            chk($sformatf("wrap_rd_en%0d", i), 32'(rd_en), 32'd1);
            chk($sformatf("wrap_raddr%0d", i), 32'(raddr), 32'(i % 8));
            cyc();
            chk($sformatf("wrap_rptr%0d", i),   32'(rptr),   32'(g(i + 1)));
            chk($sformatf("wrap_rempty%0d", i), 32'(rempty), 32'(i == 15));
        end
        req0 = 1'b0;
        cyc();

        // Reset asserted during beat 2 of a burst.
        do_reset();
        rq2_wptr = g(8);
        cyc();
        req0 = 1'b1;
        #1 chk("mr_gnt0_b1", 32'(gnt0), 32'd1);
        cyc();
        #1 chk("mr_raddr_b2", 32'(raddr), 32'd1);
        rrst = 1'b1;
        cyc();
        chk("mr_rvalid", 32'(rvalid), 32'd0);
        chk("mr_rptr",   32'(rptr),   32'd0);
        chk("mr_rempty", 32'(rempty), 32'd1);
        chk("mr_rd_en",  32'(rd_en),  32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk("mr_rlevel", 32'(rlevel), 32'd0);
`endif
        rrst = 1'b0;
        cyc();
        chk("mr_rempty_rel", 32'(rempty), 32'd0);
        #1;
        chk("mr_gnt0_again", 32'(gnt0), 32'd1);
        chk("mr_raddr0",     32'(raddr), 32'd0);
        req0 = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
